mips_muldiv_unit: RTL and testbench

//   Iterative multiply/divide unit in the EX stage, downstream of the ALU operand forwarding muxes.

---
 rtl/mips_muldiv_unit.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv_unit.sv
// ---------------------------------------------------------------------------
// MipsMulDivUnit (module mips_muldiv_unit)
//
// Iterative multiply/divide unit that sits in the EX stage behind the ALU
// operand forwarding muxes. It executes MULT, MULTU, DIV and DIVU with one
// radix-2 step per clock. Results land in the HI/LO registers, which MFHI
// and MFLO read. MTHI and MTLO can also load HI and LO directly.
//
// An operation runs through three states: IDLE -> CALC -> FIX -> IDLE.
// The result is written 33 edges after the start edge. While an operation
// is in flight, busy stays high so that the hazard unit can stall.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst        : asynchronous, active-high reset
//   start      : issue an operation (accepted only in IDLE)
//   op         : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   operand_a  : rs value, multiplicand / dividend
//   operand_b  : rt value, multiplier / divisor
//   flush      : squash the in-flight operation (or a start issued in IDLE)
//   hi_we      : MTHI strobe, HI <= wdata (IDLE with start low only)
//   lo_we      : MTLO strobe, LO <= wdata (IDLE with start low only)
//   wdata      : MTHI/MTLO data
//   busy       : high while an operation is in CALC or FIX
//   done       : one-cycle pulse after HI/LO take a completed result
//   hi, lo     : the HI and LO registers
// ---------------------------------------------------------------------------
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [CNT_W-1:0]   count;
    logic               is_div;
    logic               neg_main;
    logic               neg_rem;
    logic               div_zero;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;

    logic               accept;
    logic               fix_write;
    logic               reg_write_ok;

    logic               op_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_top;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;

    logic [2*WIDTH-1:0] product_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    // The hazard unit only needs to know whether an operation is in flight.
    // Both CALC and FIX count as in flight. The done cycle is already IDLE,
    // so busy is low there.
    assign busy = (state != ST_IDLE);

    // State register. Reset returns the unit to IDLE at once, whatever it
    // was doing, so a half-finished result is simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the three qualified strobes derived from it.
    //   accept       : a start that is really taken. A flush in the same
    //                  cycle wins, because that instruction is being
    //                  squashed.
    //   fix_write    : the final sign-fix edge is allowed to write HI/LO.
    //                  A flush here kills the write and the done pulse.
    //   reg_write_ok : the MTHI/MTLO window. This is IDLE with no start, and
    //                  it includes the done cycle, so a move issued right
    //                  after a result overrides that half.
    // The counter ends CALC after the step numbered WIDTH-1 (the 32nd step).
    always_comb begin
        next_state   = state;
        accept       = 1'b0;
        fix_write    = 1'b0;
        reg_write_ok = 1'b0;
        case (state)
            ST_IDLE: begin
                reg_write_ok = !start;
                if (start && !flush) begin
                    accept     = 1'b1;
                    next_state = ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    next_state = ST_IDLE;
                end else if (count == LAST_STEP) begin
                    next_state = ST_FIX;
                end
            end
            ST_FIX: begin
                fix_write  = !flush;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Operand conditioning at issue time. MULT and DIV (op[0] low) are
    // signed, so the iterative core runs on magnitudes and the signs are
    // restored in FIX. The magnitude of the most negative value wraps back
    // to itself. That is still the correct unsigned magnitude.
    always_comb begin
        op_signed = !op[0];
        abs_a     = (op_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        abs_b     = (op_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    end

    // One radix-2 step of the shared accumulator.
    //
    // Multiply: acc starts as {0, multiplier}. Each step adds the
    // multiplicand into the upper half when the low bit is set. It then
    // shifts the whole accumulator right, keeping the carry as the new top
    // bit. After WIDTH steps, acc holds the full product.
    //
    // Divide (restoring): acc starts as {0, dividend}. The upper half is the
    // partial remainder and the lower half shifts in the quotient bits. Each
    // step shifts left by one and tries to subtract the divisor from the top
    // WIDTH+1 bits. If the result is not negative, it is kept and a 1 goes
    // into the quotient. With a zero divisor, every trial succeeds. The
    // quotient then ends up all ones and the remainder is the dividend
    // itself, which is the required divide-by-zero result.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        div_top  = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_top - {1'b0, opnd};
        acc_step = acc;
        if (is_div) begin
            if (div_diff[WIDTH]) begin
                acc_step = {acc[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction applied in FIX.
    // A product or quotient is negated when the operand signs differ. A
    // remainder takes the sign of the dividend. A zero divisor always forces
    // the quotient to all ones. The remainder path already yields the
    // original dividend in that case, because negating |a| gives a back.
    always_comb begin
        product_fixed = neg_main ? -acc : acc;
        rem_fixed     = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (div_zero) begin
            quot_fixed = '1;
        end else if (neg_main) begin
            quot_fixed = -acc[WIDTH-1:0];
        end else begin
            quot_fixed = acc[WIDTH-1:0];
        end
    end

    // Iteration datapath. Everything an operation needs is captured on the
    // accept edge. Changes on the input pins after that do not disturb the
    // running op. A start while busy never reaches here, because accept is
    // only raised in IDLE. For a multiply, the multiplier sits in the low
    // half of acc and the multiplicand is held in opnd. For a divide, the
    // dividend sits in the low half of acc and the divisor is held in opnd.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            is_div   <= 1'b0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            opnd     <= '0;
        end else if (accept) begin
            count    <= '0;
            is_div   <= op[1];
            neg_main <= op_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            neg_rem  <= op_signed && operand_a[WIDTH-1];
            div_zero <= (operand_b == '0);
            if (op[1]) begin
                acc  <= {{WIDTH{1'b0}}, abs_a};
                opnd <= abs_b;
            end else begin
                acc  <= {{WIDTH{1'b0}}, abs_b};
                opnd <= abs_a;
            end
        end else if (state == ST_CALC && !flush) begin
            acc   <= acc_step;
            count <= count + CNT_W'(1);
        end
    end

    // Architectural HI/LO registers and the done pulse.
    // A completed op writes both halves. A multiply writes the full
    // 2*WIDTH-bit product. A divide writes remainder to HI and quotient to
    // LO. MTHI/MTLO writes only happen in the IDLE window, so they never
    // collide with a result write. Both strobes together update both halves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= fix_write;
            if (fix_write) begin
                if (is_div) begin
                    hi <= rem_fixed;
                    lo <= quot_fixed;
                end else begin
                    hi <= product_fixed[2*WIDTH-1:WIDTH];
                    lo <= product_fixed[WIDTH-1:0];
                end
            end else begin
                if (reg_write_ok && hi_we) begin
                    hi <= wdata;
                end
                if (reg_write_ok && lo_we) begin
                    lo <= wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// ---------------------------------------------------------------------------
// Testbench for mips_muldiv_unit.
//
// The stimulus process issues operations. For each one it pushes the
// expected {hi, lo} into a queue. A separate monitor pops that queue
// whenever the DUT raises done and compares the result. The reference model
// is plain 64-bit integer arithmetic. SystemVerilog division truncates
// toward zero and gives the remainder the sign of the dividend, which is
// the MIPS rule.
// ---------------------------------------------------------------------------
module tb_mips_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         flush;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } result_t;

    result_t      expq[$];
    result_t      mon_e;
    int           total = 0;
    int           bad   = 0;
    logic [31:0]  arch_hi;
    logic [31:0]  arch_lo;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // One comparison. Every check in the bench funnels through here, so
    // total and bad always stay in step with the FAIL lines.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Reference model. It uses 64-bit integer arithmetic directly from the
    // instruction definitions.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa;
        longint          sd;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned uq;
        longint unsigned ur;
        sa = $signed(a);
        sd = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (o)
            2'b00: return sa * sd;
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                q = sa / sd;
                r = sa % sd;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Operand picker. It biases toward the corner values that stress sign
    // handling and the divider.
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard monitor. Any done pulse must match the oldest pending
    // expectation. A done pulse with nothing pending is an error.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got hi=%h lo=%h expected no result", hi, lo);
            end else begin
                mon_e = expq.pop_front();
                checkOutput("result_hi", {32'h0, hi}, {32'h0, mon_e.hi});
                checkOutput("result_lo", {32'h0, lo}, {32'h0, mon_e.lo});
            end
        end
    end

    // Issue one operation, called on a negedge while the unit is idle.
    // The task measures how long busy stays high. It can optionally inject
    // a stray start plus MTHI/MTLO in cycle disturb_at. It can optionally
    // flush in cycle flush_at. Cycle 1 is the cycle right after the start
    // edge. The task returns on the negedge where busy first drops.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input int disturb_at,
                                 input int flush_at);
        result_t     e;
        logic [63:0] r;
        int          n;
        r     = model(o, a, b);
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        start = 1'b1;
        op    = o;
        operand_a = a;
        operand_b = b;
        if (flush_at == 0) expq.push_back(e);
        @(negedge clk);
        start     = 1'b0;
        op        = 2'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
        n = 0;
        while (busy && n < 60) begin
            n++;
            if (n == disturb_at) begin
                start = 1'b1;
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = $urandom;
            end
            if (n == flush_at) flush = 1'b1;
            @(negedge clk);
            start = 1'b0;
            hi_we = 1'b0;
            lo_we = 1'b0;
            flush = 1'b0;
        end
        if (flush_at != 0) begin
            checkOutput("flush_busy_cycles", 64'(n), 64'(flush_at));
            checkOutput("flush_no_done", {63'h0, done}, 64'h0);
            repeat (40) @(negedge clk);
            checkOutput("flush_hi_kept", {32'h0, hi}, {32'h0, arch_hi});
            checkOutput("flush_lo_kept", {32'h0, lo}, {32'h0, arch_lo});
            checkOutput("flush_stays_idle", {63'h0, busy}, 64'h0);
        end else begin
            checkOutput("busy_cycles", 64'(n), 64'd33);
            checkOutput("done_pulse", {63'h0, done}, 64'h1);
            arch_hi = e.hi;
            arch_lo = e.lo;
        end
    endtask

    // One idle cycle after a done pulse. It confirms that done lasts
    // exactly one cycle.
    task automatic finishOp();
        @(negedge clk);
        checkOutput("done_fall", {63'h0, done}, 64'h0);
    endtask

    // MTHI/MTLO while idle. Both halves are then checked against the
    // architectural expectation.
    task automatic writeHiLo(input logic hwe, input logic lwe, input logic [31:0] d);
        hi_we = hwe;
        lo_we = lwe;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (hwe) arch_hi = d;
        if (lwe) arch_lo = d;
        checkOutput("mt_hi", {32'h0, hi}, {32'h0, arch_hi});
        checkOutput("mt_lo", {32'h0, lo}, {32'h0, arch_lo});
    endtask

    // Watchdog, so that a hung DUT still terminates the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = '0;
        operand_b = '0;
        flush     = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        wdata     = '0;
        arch_hi   = '0;
        arch_lo   = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {63'h0, busy}, 64'h0);
        checkOutput("reset_done", {63'h0, done}, 64'h0);
        checkOutput("reset_hi", {32'h0, hi}, 64'h0);
        checkOutput("reset_lo", {32'h0, lo}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed arithmetic cases");
        applyStimulus(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0);
        finishOp();
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        finishOp();
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
        finishOp();
        applyStimulus(2'b11, 32'd100, 32'd7, 0, 0);
        finishOp();
        applyStimulus(2'b11, 32'd100, 32'd0, 0, 0);
        finishOp();
        applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        finishOp();
        applyStimulus(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 0, 0);
        finishOp();

        $display("[TB] flush and reset during an op");
        writeHiLo(1'b1, 1'b0, 32'h11);
        writeHiLo(1'b0, 1'b1, 32'h22);
        applyStimulus(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 0, 10);
        applyStimulus(2'b10, 32'h0000_1000, 32'h0000_0003, 0, 33);

        // A start and a flush in the same idle cycle: the flush wins.
        start     = 1'b1;
        flush     = 1'b1;
        op        = 2'b01;
        operand_a = 32'h5;
        operand_b = 32'h6;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flush_beats_start", {63'h0, busy}, 64'h0);
        repeat (40) @(negedge clk);

        // Reset in cycle 10 of a MULT throws away everything.
        start     = 1'b1;
        op        = 2'b00;
        operand_a = 32'hFFFF_0000;
        operand_b = 32'h0000_0123;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midop_reset_hi", {32'h0, hi}, 64'h0);
        checkOutput("midop_reset_lo", {32'h0, lo}, 64'h0);
        checkOutput("midop_reset_busy", {63'h0, busy}, 64'h0);
        @(negedge clk);
        rst     = 1'b0;
        arch_hi = '0;
        arch_lo = '0;
        repeat (40) @(negedge clk);
        checkOutput("post_reset_idle", {63'h0, busy}, 64'h0);

        $display("[TB] interference while busy and MTHI in the done cycle");
        writeHiLo(1'b1, 1'b1, 32'hA5A5_5A5A);
        applyStimulus(2'b10, 32'hFFFF_FF00, 32'h0000_0007, 5, 0);
        hi_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        hi_we   = 1'b0;
        arch_hi = 32'hCAFE_F00D;
        checkOutput("done_cycle_mthi", {32'h0, hi}, {32'h0, arch_hi});
        checkOutput("done_cycle_lo_kept", {32'h0, lo}, {32'h0, arch_lo});
        checkOutput("done_fall_mthi", {63'h0, done}, 64'h0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), pick(), pick(), 0, 0);
            finishOp();
            if ($urandom_range(0, 4) == 0) begin
                writeHiLo(1'($urandom), 1'($urandom), $urandom);
            end
        end

        @(negedge clk);
        checkOutput("scoreboard_empty", 64'(expq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
